// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter giving four requesters turns on one level-driven 5-byte UART transmitter.
// Latency: DataEn rises one cycle after an idle grant; Ack arrives HOLD_CYCLES+GAP_CYCLES cycles after that.
// Backpressure: Req is a level held until Ack; while Busy, new requests simply wait for a later turn.
module uart_tx_arbiter #(
   parameter int HOLD_CYCLES = 290000,
   parameter int GAP_CYCLES  = 16,
   parameter int CNT_W       = 19
) (
   input  logic         Clk,
   input  logic         RstN,
   input  logic [3:0]   Req,
   input  logic [159:0] ReqData,
   output logic [3:0]   Ack,
   output logic         Busy,
   output logic [1:0]   GrantId,
   output logic         DataEn,
   output logic [39:0]  DataIn
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Terminal counts; the timer restarts from zero in each timed state and never wraps.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       grant_q, grant_d;
   logic             data_en_q, data_en_d;
   logic [39:0]      data_q, data_d;
   logic [3:0]       ack_q, ack_d;
   logic             busy_q, busy_d;

   logic [3:0]       elig;
   logic             found;
   logic [1:0]       sel;
   logic [1:0]       idx;

   // Rotating first-set search over Req, starting at the pointer; the requester
   // being acknowledged this cycle is masked so it cannot be re-granted at once.
   always_comb begin
      elig  = Req & ~ack_q;
      found = 1'b0;
      sel   = 2'd0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + k[1:0];
         if (!found && elig[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Next-state and output logic: IDLE grants, HOLD keeps DataEn high, GAP forces it low then acks.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_en_d = data_en_q;
      data_d    = data_q;
      ack_d     = 4'b0000;
      busy_d    = busy_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               data_d    = ReqData[40*sel +: 40];
               data_en_d = 1'b1;
               grant_d   = sel;
               busy_d    = 1'b1;
               timer_d   = '0;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (timer_q == HOLD_LAST) begin
               data_en_d = 1'b0;
               timer_d   = '0;
               state_d   = ST_GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (timer_q == GAP_LAST) begin
               ack_d[grant_q] = 1'b1;
               busy_d         = 1'b0;
               ptr_d          = grant_q + 2'd1;
               timer_d        = '0;
               state_d        = ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            data_en_d = 1'b0;
            busy_d    = 1'b0;
            timer_d   = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State register; reset mid-frame drops DataEn and discards the pending Ack.
   always_ff @(posedge Clk) begin
      if (!RstN) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         ptr_q     <= 2'd0;
         grant_q   <= 2'd0;
         data_en_q <= 1'b0;
         data_q    <= '0;
         ack_q     <= 4'b0000;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         data_en_q <= data_en_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
      end
   end

   assign Ack     = ack_q;
   assign Busy    = busy_q;
   assign GrantId = grant_q;
   assign DataEn  = data_en_q;
   assign DataIn  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-schedule reference model.
// Latency: compares every output one step after each rising edge.
// Backpressure: requesters hold Req until their Ack, then drop or keep it per phase.
module tb_uart_tx_arbiter;

   localparam int H = 20;
   localparam int G = 3;

   logic         Clk;
   logic         RstN;
   logic [3:0]   Req;
   logic [159:0] ReqData;
   logic [3:0]   Ack;
   logic         Busy;
   logic [1:0]   GrantId;
   logic         DataEn;
   logic [39:0]  DataIn;

   uart_tx_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(5)) dut (
      .Clk(Clk), .RstN(RstN), .Req(Req), .ReqData(ReqData),
      .Ack(Ack), .Busy(Busy), .GrantId(GrantId), .DataEn(DataEn), .DataIn(DataIn)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a frame is "active" with an offset counted from its grant edge.
   bit          m_active;
   int          m_off;
   int          m_gid;
   int          m_ptr;
   logic [39:0] m_data;
   logic [3:0]  m_ack;

   bit keep_after_ack;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [3:0] elig;
      int id;
      if (!RstN) begin
         m_active = 0; m_off = 0; m_gid = 0; m_ptr = 0; m_data = '0; m_ack = '0;
      end else if (m_active) begin
         m_ack = '0;
         if (m_off == H + G - 1) begin
            m_active = 0;
            m_ack[m_gid] = 1'b1;
            m_ptr = (m_gid + 1) % 4;
         end else begin
            m_off++;
         end
      end else begin
         elig  = Req & ~m_ack;
         m_ack = '0;
         for (int k = 0; k < 4; k++) begin
            id = (m_ptr + k) % 4;
            if (elig[id] && !m_active) begin
               m_active = 1; m_off = 0; m_gid = id;
               m_data = ReqData[40*id +: 40];
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      #1;
      chk("DataEn",  40'(DataEn),  40'(m_active && (m_off < H)));
      chk("Busy",    40'(Busy),    40'(m_active));
      chk("Ack",     40'(Ack),     40'(m_ack));
      chk("GrantId", 40'(GrantId), 40'(m_gid));
      chk("DataIn",  DataIn,       m_data);
      @(negedge Clk);
      for (int i = 0; i < 4; i++)
         if (m_ack[i] && !keep_after_ack) Req[i] = 1'b0;
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   initial begin
      RstN = 1'b0; Req = '0; ReqData = '0; keep_after_ack = 0;
      m_active = 0; m_off = 0; m_gid = 0; m_ptr = 0; m_data = '0; m_ack = '0;
      run(3);
      RstN = 1'b1;

      // Single request on requester 0.
      Req = 4'b0001;
      ReqData[39:0] = 40'h1122334455;
      run(30);

      // All four contend, held back-to-back.
      keep_after_ack = 1;
      for (int i = 0; i < 4; i++) ReqData[40*i +: 40] = {8'(i), 32'($urandom)};
      Req = 4'b1111;
      run(110);

      // Requesters 0 and 3 only; pointer wraps 3 -> 0.
      Req = 4'b1001;
      run(100);

      // Mid-frame Req drop and data change are ignored.
      Req = 4'b0000;
      run(30);
      keep_after_ack = 0;
      Req = 4'b0100;
      run(10);
      Req = 4'b0000;
      ReqData = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run(20);

      // Reset mid-HOLD with Req still high.
      Req = 4'b0010;
      run(12);
      RstN = 1'b0;
      run(1);
      RstN = 1'b1;
      run(30);

      // Random traffic with occasional reset.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!Req[i] && ($urandom % 8 == 0)) begin
               Req[i] = 1'b1;
               ReqData[40*i +: 40] = {8'($urandom), 32'($urandom)};
            end else if (Req[i] && ($urandom % 16 == 0)) begin
               ReqData[40*i +: 40] = {8'($urandom), 32'($urandom)};
            end else if (Req[i] && ($urandom % 64 == 0)) begin
               Req[i] = 1'b0;
            end
         end
         keep_after_ack = ($urandom % 2) == 0;
         RstN = ($urandom % 300) != 0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
